// File: rtl/sm_accumulator.sv
// Sign-magnitude frame accumulator: sums COUNT samples with saturation, holds the sum until downstream takes it.
// Optional sticky saturation flag on out_sat when SM_ACC_STICKY_SAT_EN is defined.
module sm_accumulator #(
  parameter int N     = 8,
  parameter int COUNT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sat
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_r, state_nx_s;
  logic [N-1:0]  acc_r, acc_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic          accept_s;
  logic          release_s;

  // A zero magnitude always yields sign 0, so negative zero never escapes.
  function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic         sgn;
    sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
    if (a[N-1] == b[N-1]) begin
      mag = sum[N-1] ? {(N-1){1'b1}} : sum[N-2:0];
      sgn = a[N-1];
    end else if (a[N-2:0] >= b[N-2:0]) begin
      mag = a[N-2:0] - b[N-2:0];
      sgn = a[N-1];
    end else begin
      mag = b[N-2:0] - a[N-2:0];
      sgn = b[N-1];
    end
    return {sgn & (mag != {(N-1){1'b0}}), mag};
  endfunction

`ifdef SM_ACC_STICKY_SAT_EN
  logic sat_r, sat_nx_s;

  function automatic logic sm_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] sum;
    sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
    return (a[N-1] == b[N-1]) && sum[N-1];
  endfunction

  assign out_sat = sat_r;
`else
  assign out_sat = 1'b0;
`endif

  assign in_ready  = (state_r == ACC);
  assign out_valid = (state_r == HOLD);
  assign out_data  = acc_r;
  assign accept_s  = in_valid && in_ready;
  assign release_s = out_valid && out_ready;

  // Next-state and datapath update; clear outranks both handshakes.
  always_comb begin
    state_nx_s = state_r;
    acc_nx_s   = acc_r;
    cnt_nx_s   = cnt_r;
`ifdef SM_ACC_STICKY_SAT_EN
    sat_nx_s   = sat_r;
`endif
    if (clear) begin
      state_nx_s = ACC;
      acc_nx_s   = {N{1'b0}};
      cnt_nx_s   = {CW{1'b0}};
`ifdef SM_ACC_STICKY_SAT_EN
      sat_nx_s   = 1'b0;
`endif
    end else if (accept_s) begin
      acc_nx_s = sm_add(acc_r, in_data);
`ifdef SM_ACC_STICKY_SAT_EN
      sat_nx_s = sat_r | sm_ovf(acc_r, in_data);
`endif
      if (cnt_r == CW'(COUNT - 1)) begin
        state_nx_s = HOLD;
        cnt_nx_s   = {CW{1'b0}};
      end else begin
        cnt_nx_s = cnt_r + CW'(1);
      end
    end else if (release_s) begin
      state_nx_s = ACC;
      acc_nx_s   = {N{1'b0}};
      cnt_nx_s   = {CW{1'b0}};
`ifdef SM_ACC_STICKY_SAT_EN
      sat_nx_s   = 1'b0;
`endif
    end else begin
      state_nx_s = state_r;
    end
  end

  // State, accumulator and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACC;
      acc_r   <= {N{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      acc_r   <= acc_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

`ifdef SM_ACC_STICKY_SAT_EN
  // Sticky saturation flag for the frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_r <= 1'b0;
    end else begin
      sat_r <= sat_nx_s;
    end
  end
`endif

endmodule

// File: tb/tb_sm_accumulator.sv
// Directed self-checking bench for sm_accumulator (N=8, COUNT=4).
module tb_sm_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       clear = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_sat;

  int total = 0;
  int bad = 0;
  logic sat_exp;

`ifdef SM_ACC_STICKY_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  sm_accumulator #(.N(8), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  // Drive one sample for one cycle; called 1 ns after a rising edge.
  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    push(a); push(b); push(c); push(d);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", out_sat); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    push4(8'h03, 8'h05, 8'h82, 8'h01);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h07) begin bad++; $display("FAIL basic_sum got v=%b d=%h exp v=1 d=07", out_valid, out_data); end
    total++; if (out_sat !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL basic_flags got sat=%b rdy=%b exp sat=0 rdy=0", out_sat, in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL basic_oneshot got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
  endtask

  task automatic test_sat;
    sat_exp = SAT_EN;
    push4(8'h64, 8'h64, 8'h64, 8'h64);
    total++; if (out_data !== 8'h7F) begin bad++; $display("FAIL sat_pos got=%h exp=7f", out_data); end
    total++; if (out_sat !== sat_exp) begin bad++; $display("FAIL sat_flag got=%b exp=%b", out_sat, sat_exp); end
    @(posedge clk); #1;
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL sat_cleared got=%b exp=0", out_sat); end
    push4(8'hE4, 8'hE4, 8'hE4, 8'hE4);
    total++; if (out_data !== 8'hFF) begin bad++; $display("FAIL sat_neg got=%h exp=ff", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_signs;
    push4(8'h05, 8'h85, 8'h80, 8'h00);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin bad++; $display("FAIL neg_zero got v=%b d=%h exp v=1 d=00", out_valid, out_data); end
    @(posedge clk); #1;
    push4(8'h02, 8'h85, 8'h01, 8'h80);
    total++; if (out_data !== 8'h82) begin bad++; $display("FAIL larger_neg got=%h exp=82", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    push4(8'h01, 8'h01, 8'h01, 8'h01);
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 8'h04) begin bad++; $display("FAIL hold_%0d got v=%b rdy=%b d=%h exp v=1 rdy=0 d=04", i, out_valid, in_ready, out_data); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h04) begin bad++; $display("FAIL hold_last got v=%b d=%h exp v=1 d=04", out_valid, out_data); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
  endtask

  task automatic test_clear;
    push(8'h01); push(8'h01);
    in_valid = 1'b1; in_data = 8'h01; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL clear_acc got=%h exp=00", out_data); end
    push(8'h01); push(8'h01); push(8'h01);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clear_count got v=%b exp=0", out_valid); end
    push(8'h01);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h04) begin bad++; $display("FAIL clear_frame got v=%b d=%h exp v=1 d=04", out_valid, out_data); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    push4(8'h02, 8'h02, 8'h02, 8'h02);
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin bad++; $display("FAIL clear_hold got v=%b d=%h exp v=0 d=00", out_valid, out_data); end
  endtask

  task automatic test_reset_midframe;
    push(8'h10); push(8'h10);
    rst_n = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sat !== 1'b0) begin bad++; $display("FAIL rst_mid got v=%b d=%h s=%b exp 0 00 0", out_valid, out_data, out_sat); end
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
    push4(8'h01, 8'h01, 8'h01, 8'h01);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h04) begin bad++; $display("FAIL rst_mid_frame got v=%b d=%h exp v=1 d=04", out_valid, out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    push4(8'h81, 8'h81, 8'h81, 8'h81);
    total++; if (out_data !== 8'h84) begin bad++; $display("FAIL b2b_first got=%h exp=84", out_data); end
    @(posedge clk); #1;
    push4(8'h7F, 8'h81, 8'h00, 8'h03);
    total++; if (out_data !== 8'h7F) begin bad++; $display("FAIL b2b_second got=%h exp=7f", out_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_signs();
    test_backpressure();
    test_clear();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm_accumulator.md
SM_ACCUMULATOR -- requirements
Module: sm_accumulator

Interface
REQ-001 SHALL have parameter N, default 8: data width in sign-magnitude format, MSB = sign, N-1 magnitude bits, N>=3.
REQ-002 SHALL have parameter COUNT, default 4: accepted samples per frame, COUNT>=1.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: upstream sample valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-007 SHALL have port in_data, input, N: sign-magnitude sample.
REQ-008 SHALL have port clear, input, 1: synchronous discard of the partial frame.
REQ-009 SHALL have port out_valid, output, 1: frame sum available.
REQ-010 SHALL have port out_ready, output handshake input, 1: downstream accepts the sum.
REQ-011 SHALL have port out_data, output, N: sign-magnitude frame sum.
REQ-012 SHALL have port out_sat, output, 1: saturation flag for the current frame (see Configuration).

Function
REQ-013 SHALL implement two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 SHALL accept a sample when in_valid&&in_ready, adding it into a registered N-bit accumulator acc and incrementing a sample counter.
REQ-015 Addition SHALL be sign-magnitude: same signs add magnitudes; differing signs subtract the smaller magnitude from the larger and take the sign of the larger.
REQ-016 Same-sign magnitude overflow beyond 2^(N-1)-1 SHALL saturate to magnitude 2^(N-1)-1 with the operands' sign.
REQ-017 A zero-magnitude result SHALL always have sign 0; input 1 followed by N-1 zeros (negative zero) SHALL be treated as +0.
REQ-018 On acceptance of the COUNT-th sample, the block SHALL move to HOLD on the next edge; out_data=acc, 1-cycle latency from the last accepted sample.
REQ-019 In HOLD, out_data and out_sat SHALL stay stable until out_valid&&out_ready.
REQ-020 On out_valid&&out_ready, the block SHALL clear acc to 0 and the counter to 0, and return to ACC on the next edge. The next sample is accepted no earlier than the following cycle.
REQ-021 clear=1 SHALL, in either state, zero acc, the counter and the sat flag, and enter ACC. clear SHALL take priority over a simultaneous input or output handshake. The colliding sample or sum is dropped.
REQ-022 For COUNT=1, every accepted sample SHALL be forwarded as a one-sample frame after canonicalising negative zero to +0.

Reset
REQ-023 rst_n=0 SHALL immediately force state ACC, acc=0, counter=0, out_valid=0, out_data=0, out_sat=0, and in_ready=1 once released.
REQ-024 Reset asserted mid-frame or in HOLD SHALL discard all partial and pending results without emitting a frame.

Configuration
REQ-025 Macro SM_ACC_STICKY_SAT_EN defined: out_sat SHALL be a sticky flag, set by any saturating addition in the frame and cleared by the frame handshake, clear, or reset.
REQ-026 Macro SM_ACC_STICKY_SAT_EN undefined: out_sat SHALL be tied 0, with no saturation-flag register; the saturating arithmetic is unchanged.

Verification (N=8, COUNT=4)
REQ-027 Inputs 0x03,0x05,0x82,0x01 with out_ready=1 SHALL produce out_data=0x07, out_valid for 1 cycle, out_sat=0.
REQ-028 Inputs 0x64 x4 SHALL produce out_data=0x7F and, with SM_ACC_STICKY_SAT_EN, out_sat=1; inputs 0xE4 x4 SHALL produce 0xFF.
REQ-029 Inputs 0x05,0x85,0x80,0x00 SHALL produce out_data=0x00, never 0x80.
REQ-030 A completed frame with out_ready=0 for 3 cycles SHALL hold out_valid=1, in_ready=0 and a stable out_data, and SHALL release on the 4th cycle when out_ready=1.
REQ-031 Two samples then clear=1 coinciding with a valid third, followed by 0x01 x4, SHALL produce out_data=0x04.
REQ-032 rst_n pulsed low mid-frame after 0x10,0x10, followed by 0x01 x4, SHALL produce out_data=0x04, with outputs 0 during reset.
